// File: rtl/binary_mul_pkg.sv
// Shared types and default widths for the multiplier accumulation stage.
package binary_mul_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/binary_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry-out and flags it.
module binary_sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        sat  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/binary_mul_8_acc.sv
// Dot-product accumulator behind the 8x8 multiplier: sums len products and
// holds the result on a valid/ready port until taken.
//
//  state | meaning
//  IDLE  | waiting for start
//  ACCUM | summing valid products, busy=1
//  HOLD  | result presented, out_valid=1, frozen until out_ready
module binary_mul_8_acc
    import binary_mul_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              busy,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic             launch;
    logic             last_term;

    assign prod_ext = ACC_W'(prod_in);
    assign acc_out  = acc;

    binary_sat_add #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (sum),
        .sat (sat)
    );

    // A new job is accepted from IDLE, or straight out of HOLD when the
    // current result is consumed in the same cycle (no bubble).
    always_comb begin
        launch    = 1'b0;
        last_term = 1'b0;
        if (start && (state == IDLE || (state == HOLD && out_ready)))
            launch = 1'b1;
        if (cnt == len_q - CNT_W'(1))
            last_term = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (launch) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
            if (len != '0) begin
                len_q     <= len;
                state     <= ACCUM;
                busy      <= 1'b1;
                out_valid <= 1'b0;
            end else begin
                state     <= HOLD;
                busy      <= 1'b0;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_valid) begin
                        acc <= sum;
                        if (sat)
                            ovf <= 1'b1;
                        cnt <= cnt + CNT_W'(1);
                        if (last_term) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_mul_8_acc.sv
// Directed and randomised checks of the accumulation stage (ACC_W=17 so
// saturation is reachable with 16-bit products).
module tb_binary_mul_8_acc;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 17;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              busy;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;
    logic              out_valid;
    logic              out_ready;

    int total;
    int bad;

    binary_mul_8_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .busy       (busy),
        .acc_out    (acc_out),
        .ovf        (ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; prod_in = '0;
        prod_valid = 1'b0; out_ready = 1'b0;
        #12;
        total++;
        if ({busy, out_valid, ovf, acc_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b ov=%0b ovf=%0b acc=%0h want all 0",
                     busy, out_valid, ovf, acc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] vals [3];
        vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy: got %0b want 1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            prod_in = vals[i]; prod_valid = 1'b1;
            tick();
            if (i < 2) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL basic_early_valid: term %0d got %0b want 0", i, out_valid);
                end
            end
        end
        prod_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || acc_out !== 17'd600 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got ov=%0b acc=%0d ovf=%0b busy=%0b want 1 600 0 0",
                     out_valid, acc_out, ovf, busy);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_release: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_len0();
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || acc_out !== 17'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_result: got ov=%0b acc=%0d ovf=%0b busy=%0b want 1 0 0 0",
                     out_valid, acc_out, ovf, busy);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL len0_release: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prod_in = 16'hFFFF; prod_valid = 1'b1;
            tick();
            if (i == 1) begin
                total++;
                if (acc_out !== 17'h1FFFE || ovf !== 1'b0) begin
                    bad++;
                    $display("FAIL sat_partial: got acc=%0h ovf=%0b want 1fffe 0", acc_out, ovf);
                end
            end
        end
        prod_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || acc_out !== 17'h1FFFF || ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_result: got ov=%0b acc=%0h ovf=%0b want 1 1ffff 1",
                     out_valid, acc_out, ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            prod_in = 16'(i); prod_valid = 1'b1;
            tick();
            if (i < 4) begin
                prod_valid = 1'b0;
                prod_in = 16'd999;
                if (i == 2) begin
                    start = 1'b1; len = 8'd9;
                end
                tick();
                start = 1'b0;
            end
        end
        prod_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || acc_out !== 17'd10 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL gap_result: got ov=%0b acc=%0d ovf=%0b want 1 10 0", out_valid, acc_out, ovf);
        end
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0;
            prod_valid = (k % 2 == 0);
            prod_in = 16'd50;
            start = (k % 2 == 1);
            len = 8'd1;
            tick();
            total++;
            if (out_valid !== 1'b1 || acc_out !== 17'd10) begin
                bad++;
                $display("FAIL hold_frozen: cycle %0d got ov=%0b acc=%0d want 1 10", k, out_valid, acc_out);
            end
        end
        prod_valid = 1'b0;
        out_ready = 1'b1; start = 1'b1; len = 8'd2;
        tick();
        out_ready = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || acc_out !== 17'd0) begin
            bad++;
            $display("FAIL b2b_launch: got busy=%0b ov=%0b acc=%0d want 1 0 0", busy, out_valid, acc_out);
        end
        prod_in = 16'd7; prod_valid = 1'b1;
        tick();
        prod_in = 16'd8;
        tick();
        prod_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || acc_out !== 17'd15 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result: got ov=%0b acc=%0d ovf=%0b want 1 15 0", out_valid, acc_out, ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 16'd1;
        tick();
        prod_in = 16'd2;
        tick();
        prod_valid = 1'b0;
        total++;
        if (acc_out !== 17'd3 || busy !== 1'b1) begin
            bad++; $display("FAIL midjob_partial: got acc=%0d busy=%0b want 3 1", acc_out, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, ovf, acc_out} !== '0) begin
            bad++;
            $display("FAIL async_reset: got busy=%0b ov=%0b ovf=%0b acc=%0h want all 0",
                     busy, out_valid, ovf, acc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        prod_in = 16'd5; prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || acc_out !== 17'd5 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_job: got ov=%0b acc=%0d ovf=%0b want 1 5 0", out_valid, acc_out, ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Multiplier emulated in-bench: en/a/b chosen this cycle appear as
    // prod_valid/prod_in one cycle later.
    task automatic test_random();
        logic [17:0] exp_sum;
        logic        exp_ovf;
        logic        pend_v;
        logic [15:0] pend_p;
        logic        en;
        logic [15:0] pp;
        logic [7:0]  a, b;
        logic        in_hold;
        int          jl, issued, waited;
        pend_v = 1'b0; pend_p = '0; in_hold = 1'b0;
        for (int job = 0; job < 1000; job++) begin
            jl = $urandom_range(0, 5);
            start = 1'b1; len = 8'(jl); out_ready = in_hold; prod_valid = 1'b0;
            tick();
            start = 1'b0; out_ready = 1'b0;
            exp_sum = '0; exp_ovf = 1'b0; issued = 0; waited = 0;
            while (out_valid !== 1'b1 && waited < 200) begin
                en = (issued < jl) && ($urandom_range(0, 2) != 0);
                pp = '0;
                if (en) begin
                    a = 8'($urandom_range(0, 255));
                    b = 8'($urandom_range(0, 255));
                    pp = 16'(a) * 16'(b);
                    exp_sum = exp_sum + 18'(pp);
                    if (exp_sum > 18'h1FFFF) begin
                        exp_sum = 18'h1FFFF;
                        exp_ovf = 1'b1;
                    end
                    issued++;
                end
                prod_valid = pend_v; prod_in = pend_p;
                pend_v = en; pend_p = pp;
                tick();
                waited++;
            end
            prod_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL rand_timeout: job %0d len %0d out_valid never rose", job, jl);
                return;
            end
            total++;
            if (acc_out !== exp_sum[16:0] || ovf !== exp_ovf) begin
                bad++;
                $display("FAIL rand_result: job %0d len %0d got acc=%0h ovf=%0b want %0h %0b",
                         job, jl, acc_out, ovf, exp_sum[16:0], exp_ovf);
            end
            for (int w = 0; w < int'($urandom_range(0, 2)); w++)
                tick();
            if ($urandom_range(0, 1) == 1) begin
                in_hold = 1'b1;
            end else begin
                in_hold = 1'b0;
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
        if (in_hold) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_len0();
        test_saturate();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
